clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel programmable clock divider running from the 12 MHz board clock. Each channel produces a divided clock enable/clock (`clk_out`) and a one-cycle `tick` at every period start. The divisor can be changed at runtime through a valid/ready config port. New divisors and enable changes take effect only at period boundaries, so outputs never glitch or truncate a phase. It sits beside the SoC clocking logic and feeds peripheral timebases (UART, SPI, PWM) that need several independent, software-tunable rates.

## Interface
- `NUM_CH`, 2: number of independent divider channels (≥1).
- `CNT_W`, 8: divisor/counter width; max divisor 2^CNT_W−1.
- `DEFAULT_DIV`, 12: divisor loaded on reset (2 ≤ DEFAULT_DIV < 2^CNT_W).
- `clk_12mhz`  in  1  system clock, 12 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  NUM_CH  per-channel run request.
- `cfg_valid`  in  1  config write request.
- `cfg_ch`  in  max(1,$clog2(NUM_CH))  target channel of the write.
- `cfg_div`  in  CNT_W  requested divisor N.
- `cfg_ready`  out  1  write accepted when `cfg_valid && cfg_ready`.
- `cfg_err`  out  1  one-cycle pulse: write with `cfg_div < 2` or `cfg_ch ≥ NUM_CH`, discarded.
- `clk_out`  out  NUM_CH  divided clocks, registered.
- `tick`  out  NUM_CH  one-cycle pulse coincident with each `clk_out` rising edge.
- `pending`  out  NUM_CH  divisor written but not yet applied.

## Operation
- Per channel: state IDLE/RUN, counter `c` (CNT_W), active divisor N, high length H = ceil(N/2), shadow divisor S, `pending` flag.
- Reset (async, any time, including mid-period): state IDLE, c=0, N=S=DEFAULT_DIV, pending=0, clk_out=0, tick=0, cfg_err=0. Reset does not wait for a period boundary.
- IDLE, en=0: hold c=0, clk_out=0.
- IDLE, en=1 on an edge: go to RUN, c←1 (mod N), clk_out←1, tick←1. This edge counts as c=0 of the first period.
- RUN on each edge:
  - clk_out←(c < H)
  - tick←(c==0)
  - c←(c==N−1) ? 0 : c+1
- RUN at the wrap edge (c==N−1) with en=0: go to IDLE, c←0, clk_out←0. The final low phase always completes. en deasserted mid-period has no effect until the wrap.
- Waveform: N even gives 50% duty. N odd gives a high phase one cycle longer than the low phase (N=3: 2 high, 1 low).
- Config:
  - `cfg_ready = !pending[cfg_ch]` (combinational), or 1 when `cfg_ch` is out of range.
  - An accepted legal write sets S←cfg_div and pending←1.
  - An illegal write pulses `cfg_err` the next cycle and changes nothing.
- Apply: when pending=1, N←S, H←ceil(S/2), pending←0 at the next wrap edge in RUN or the next edge in IDLE. The new N governs the period starting after that edge.
- Simultaneous events:
  - Apply and wrap on the same edge: the new N is used from c=0.
  - Write to channel k while channel k applies: `cfg_ready` is 0 that cycle and the write stalls.
  - Writes to different channels are independent.
  - en=0 with a pending apply at the wrap: apply happens, then the channel enters IDLE.

## Timing
- clk_out/tick latency: 1 cycle after the first edge sampling en=1.
- Period = N cycles exactly, with no dropped or stretched cycles across divisor changes other than at the boundary.
- cfg_err latency: 1 cycle.
- pending rises 1 cycle after the accept. It falls on the apply edge.
- All outputs are registered except `cfg_ready`.

## Structure
- Package `clk_div_pkg`:
  - `DIV_MIN=2`
  - state enum `{IDLE, RUN}`
  - function `half_up(N)` returning ceil(N/2)
- Sub-module `clk_div_chan`: one channel, containing the FSM, counter, shadow register and apply logic.
- Top `clk_div_multi`: generate loop over `clk_div_chan`, channel decode, `cfg_ready` mux, `cfg_err` register.

## Test plan
- Reset, then en[0]=1 with N=12 → clk_out[0] high 6, low 6, tick every 12 cycles. The first tick comes 1 cycle after en.
- Write cfg_div=5 to ch0 mid-period → pending[0]=1 until the wrap. The next period is 3 high, 2 low. No period is shorter than min(old, new).
- Drop en[0] at c=2 of a N=12 period → clk_out completes its high and low phases and stays 0 after the wrap. Re-asserting en restarts with a tick.
- cfg_div=1, then cfg_div=0, then cfg_ch=NUM_CH → cfg_err pulses each time and N is unchanged.
- Second write to ch1 while pending[1]=1 → cfg_ready=0, write held until the apply edge, then accepted. A write to ch0 in the same window is accepted immediately.
- Assert rst mid-high-phase → clk_out, tick and pending go to 0 asynchronously, and N returns to 12.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel programmable clock divider.
package clk_div_pkg;

    localparam int DIV_MIN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    // High-phase length of a divide-by-n period: ceil(n/2).
    function automatic int unsigned half_up(input int unsigned n);
        return (n + 32'd1) / 32'd2;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/RUN FSM, period counter, shadow divisor and
// boundary-aligned apply of divisor changes.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 12
) (
    input  logic             clk_12mhz,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pending,
    output logic             dbg_state
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(half_up(DEFAULT_DIV));

    chan_state_e      state;
    chan_state_e      state_nxt;
    logic [CNT_W-1:0] c;
    logic [CNT_W-1:0] c_nxt;
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] n_nxt;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] s;
    logic [CNT_W-1:0] s_nxt;
    logic             pending_nxt;
    logic             clk_out_nxt;
    logic             tick_nxt;
    logic             wrap;
    logic             apply;
    logic             wr_take;

    assign wrap      = (state == RUN) && (c == n - CNT_W'(1));
    assign apply     = pending && ((state == IDLE) || wrap);
    // The top only forwards writes while nothing is pending; gated again here
    // so a stray write can never overwrite a divisor waiting to be applied.
    assign wr_take   = wr && !pending;
    assign dbg_state = (state == RUN);

    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            c       <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nxt;
            c       <= c_nxt;
            clk_out <= clk_out_nxt;
            tick    <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        c_nxt       = c;
        clk_out_nxt = 1'b0;
        tick_nxt    = 1'b0;
        case (state)
            IDLE: begin
                c_nxt = '0;
                if (en) begin
                    // This edge is c=0 of the first period.
                    state_nxt   = RUN;
                    c_nxt       = CNT_W'(1);
                    clk_out_nxt = 1'b1;
                    tick_nxt    = 1'b1;
                end
            end
            RUN: begin
                clk_out_nxt = (c < h);
                tick_nxt    = (c == '0);
                if (wrap) begin
                    c_nxt = '0;
                    if (!en) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    c_nxt = c + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                c_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            n       <= DIV_RST;
            h       <= HALF_RST;
            s       <= DIV_RST;
            pending <= 1'b0;
        end else begin
            n       <= n_nxt;
            h       <= h_nxt;
            s       <= s_nxt;
            pending <= pending_nxt;
        end
    end

    // Apply and write are mutually exclusive: apply needs pending=1, a write needs pending=0.
    always_comb begin
        n_nxt       = n;
        h_nxt       = h;
        s_nxt       = s;
        pending_nxt = pending;
        if (apply) begin
            n_nxt       = s;
            h_nxt       = CNT_W'(half_up(32'(s)));
            pending_nxt = 1'b0;
        end
        if (wr_take) begin
            s_nxt       = wr_div;
            pending_nxt = 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider on the 12 MHz board clock with a
// valid/ready divisor config port shared by all channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int  NUM_CH      = 2,
    parameter int  CNT_W       = 8,
    parameter int  DEFAULT_DIV = 12,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_12mhz,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] dbg_state
);

    // Config handshake: a write transfers on a clock edge where cfg_valid && cfg_ready.
    // cfg_ready is low only while the addressed in-range channel still holds an
    // unapplied divisor; the master must keep cfg_ch/cfg_div stable until then.
    // Transferred writes that are illegal (divisor too small or no such
    // channel) are dropped and flagged by a one-cycle cfg_err.
    logic ch_in_range;
    logic div_legal;
    logic accept;
    logic legal;

    assign ch_in_range = (32'(cfg_ch) < NUM_CH);
    assign div_legal   = (cfg_div >= CNT_W'(DIV_MIN));
    assign legal       = ch_in_range && div_legal;
    assign accept      = cfg_valid && cfg_ready;

    always_comb begin
        cfg_ready = 1'b1;
        if (ch_in_range) begin
            cfg_ready = !pending[cfg_ch];
        end
    end

    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !legal;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        logic wr;
        assign wr = accept && legal && (cfg_ch == CH_W'(k));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_12mhz (clk_12mhz),
            .rst       (rst),
            .en        (en[k]),
            .wr        (wr),
            .wr_div    (cfg_div),
            .clk_out   (clk_out[k]),
            .tick      (tick[k]),
            .pending   (pending[k]),
            .dbg_state (dbg_state[k])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed plus randomized bench for clk_div_multi against a waveform-queue
// reference model built from the period rules.
module tb_clk_div_multi;

    localparam int NC  = 3;
    localparam int CW  = 8;
    localparam int DD  = 12;
    localparam int CHW = 2;

    logic          clk_12mhz = 1'b0;
    logic          rst;
    logic [NC-1:0] en;
    logic          cfg_valid;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0] cfg_div;
    logic          cfg_ready;
    logic          cfg_err;
    logic [NC-1:0] clk_out;
    logic [NC-1:0] tick;
    logic [NC-1:0] pending;
    logic [NC-1:0] dbg_state;

    // clock / reset block
    always #5 clk_12mhz = ~clk_12mhz;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    clk_div_multi #(
        .NUM_CH      (NC),
        .CNT_W       (CW),
        .DEFAULT_DIV (DD)
    ) dut (
        .clk_12mhz (clk_12mhz),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending),
        .dbg_state (dbg_state)
    );

    // reference model: each started period enqueues its whole waveform
    int checks = 0;
    int errors = 0;
    int m_n[NC];
    int m_s[NC];
    bit m_pend[NC];
    bit m_run[NC];
    bit m_clk[NC];
    bit m_tick[NC];
    bit m_err;
    logic [1:0] exp_q[NC][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_n[k]    = DD;
            m_s[k]    = DD;
            m_pend[k] = 1'b0;
            m_run[k]  = 1'b0;
            m_clk[k]  = 1'b0;
            m_tick[k] = 1'b0;
            exp_q[k].delete();
        end
        m_err = 1'b0;
    endtask

    function automatic bit model_ready();
        if (int'(cfg_ch) >= NC) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    task automatic push_period(input int k);
        for (int j = 0; j < m_n[k]; j++) begin
            exp_q[k].push_back({(j < (m_n[k] + 1) / 2) ? 1'b1 : 1'b0, (j == 0) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic apply_pending(input int k);
        if (m_pend[k]) begin
            m_n[k]    = m_s[k];
            m_pend[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit acc;
        bit legal;
        logic [1:0] e;
        if (rst) begin
            model_reset();
            return;
        end
        acc   = cfg_valid && model_ready();
        legal = (int'(cfg_ch) < NC) && (int'(cfg_div) >= 2);
        for (int k = 0; k < NC; k++) begin
            if (!m_run[k]) begin
                apply_pending(k);
                if (en[k]) begin
                    m_run[k] = 1'b1;
                    push_period(k);
                end
            end else if (exp_q[k].size() == 0) begin
                m_run[k] = 1'b0;
            end
            if (m_run[k]) begin
                e = exp_q[k].pop_front();
                m_clk[k]  = e[1];
                m_tick[k] = e[0];
                if (exp_q[k].size() == 0) begin
                    apply_pending(k);
                    if (en[k]) push_period(k);
                    else m_run[k] = 1'b0;
                end
            end else begin
                m_clk[k]  = 1'b0;
                m_tick[k] = 1'b0;
            end
            if (acc && legal && int'(cfg_ch) == k) begin
                m_s[k]    = int'(cfg_div);
                m_pend[k] = 1'b1;
            end
        end
        m_err = acc && !legal;
    endtask

    // driver tasks
    task automatic cycle();
        @(negedge clk_12mhz);
        chk("cfg_ready", cfg_ready, model_ready());
        @(posedge clk_12mhz);
        model_edge();
        #1;
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("clk_out%0d", k), clk_out[k], m_clk[k]);
            chk($sformatf("tick%0d", k), tick[k], m_tick[k]);
            chk($sformatf("pending%0d", k), pending[k], m_pend[k]);
            chk($sformatf("state%0d", k), dbg_state[k], m_run[k]);
        end
        chk("cfg_err", cfg_err, m_err);
    endtask

    task automatic write(input int ch, input int div);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_div   = CW'(div);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(input int k, input int max);
        int n = 0;
        while (!tick[k] && n < max) begin
            cycle();
            n++;
        end
        chk("wait_tick", tick[k], 1'b1);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        en        = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        model_reset();
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // default divide-by-12 on ch0, first tick one cycle after en
        en[0] = 1'b1;
        cycle();
        chk("first_tick", tick[0], 1'b1);
        repeat (30) cycle();

        // mid-period divisor change to 5
        wait_tick(0, 40);
        repeat (3) cycle();
        write(0, 5);
        chk("pending_after_write", pending[0], 1'b1);
        repeat (30) cycle();

        // back to 12, then drop en at c=2 and restart
        write(0, 12);
        repeat (20) cycle();
        wait_tick(0, 40);
        cycle();
        en[0] = 1'b0;
        repeat (20) cycle();
        chk("idle_after_drop", clk_out[0], 1'b0);
        en[0] = 1'b1;
        cycle();
        chk("restart_tick", tick[0], 1'b1);
        repeat (10) cycle();

        // illegal writes
        write(1, 1);
        write(1, 0);
        write(3, 7);
        repeat (3) cycle();

        // stalled second write to ch1, independent write to ch0
        en[1] = 1'b1;
        cycle();
        write(1, 6);
        write(0, 4);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 8'd9;
        n = 0;
        while (!model_ready() && n < 100) begin
            chk("stall_ready_low", cfg_ready, 1'b0);
            cycle();
            n++;
        end
        cycle();
        cfg_valid = 1'b0;
        chk("stall_accept", pending[1], 1'b1);
        repeat (40) cycle();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) en = NC'($urandom_range(0, 7));
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = CHW'($urandom_range(0, 3));
            cfg_div   = CW'($urandom_range(0, 14));
            cycle();
        end
        cfg_valid = 1'b0;

        // asynchronous reset in the high phase of ch0
        en = '1;
        repeat (20) cycle();
        write(2, 40);
        n = 0;
        while (!clk_out[0] && n < 300) begin
            cycle();
            n++;
        end
        chk("high_before_rst", clk_out[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("async_clk_out%0d", k), clk_out[k], m_clk[k]);
            chk($sformatf("async_tick%0d", k), tick[k], m_tick[k]);
            chk($sformatf("async_pending%0d", k), pending[k], m_pend[k]);
        end
        en = '0;
        repeat (2) cycle();
        rst = 1'b0;
        en  = 3'b001;
        repeat (30) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
